parity_sched: RTL and testbench
===============================

// Module: parity_sched
// PURPOSE
//  Shares one bit-serial byte-parity engine among NREQ requesters.
//  A round-robin arbiter grants one requester and captures its data word.
//  The engine then XOR-accumulates one bit per clock.
//  The result (parity bit plus requester ID) is presented on a valid/ready output.
//  Sits between the parity-check clients and the downstream status/err logic.
// PARAMETERS
//  NREQ  4  number of requesters (>=2)
//  DW    8  data word width per requester (>=1)
//  IDW   2  ID width = $clog2(NREQ); caller keeps consistent
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        async active-low reset
//  req        in   NREQ     request per client; level, held until gnt seen
//  in         in   NREQ*DW  data; client k at [k*DW +: DW]
//  odd_sel    in   NREQ     per-client: 1 = odd parity, 0 = even
//  gnt        out  NREQ     one-hot, 1-cycle pulse on data capture
//  busy       out  1        high whenever FSM != IDLE
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts result
//  out        out  1        parity bit = (^word) ^ odd_sel[id]
//  out_id     out  IDW      granted requester index
//  out_err    out  1        only with PARITY_SCHED_ERRCHK_EN (see CONFIGURATION)
//  exp_par    in   NREQ     only with PARITY_SCHED_ERRCHK_EN
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM=IDLE; gnt=0; busy=0; out_valid=0; out=0.
//   Also out_id=0; rr pointer=0; shift reg/counter/accumulator=0; out_err=0.
//   Any in-flight operation is discarded, with no partial output.
//  FSM: IDLE -> SHIFT -> HOLD -> IDLE.
//  IDLE: at an edge with |req, pick the first set req[i] scanning from ptr upward, wrapping.
//   That edge registers gnt[i]=1, captures in[i], odd_sel[i] and i, sets cnt=DW, acc=0, goes SHIFT.
//   Also sets ptr=(i+1) mod NREQ. No req: stay IDLE, gnt=0.
//  SHIFT: each edge: acc ^= sreg[0]; sreg >>= 1; cnt--. Leave for HOLD at the edge where cnt hits 0.
//   That edge registers out = acc^bit^odd, out_valid=1.
//   gnt is cleared the cycle after capture.
//  Latency: capture edge to out_valid high = DW cycles (8 at default).
//  HOLD: out_valid, out, out_id (and out_err) stable until out_valid&&out_ready at an edge.
//   That edge clears out_valid and goes IDLE.
//   A new grant needs >=1 IDLE cycle: 1 op per DW+2 cycles max with out_ready tied high.
//  req changes during SHIFT/HOLD are ignored; in/odd_sel are sampled only at capture.
//  A client keeping req high after gnt is re-queued. Fairness comes from ptr advance.
//  All-req case: grants rotate 0,1,2,3,0,...
//  ptr wrap: after granting NREQ-1, ptr=0.
//  out_ready high outside HOLD: no effect.
//  DW=1: SHIFT lasts exactly 1 cycle.
//  No X propagation: unused lanes are never read.
// CONFIGURATION
//  PARITY_SCHED_ERRCHK_EN defined:
//   exp_par/out_err ports exist. exp_par[i] is captured with the data at grant.
//   out_err = out ^ exp_par_captured, valid and held with out_valid; reset 0.
//  PARITY_SCHED_ERRCHK_EN undefined:
//   Ports absent, no extra flops. All other timing is identical.
// TESTING
//  1 Reset: rst_n=0 mid-SHIFT -> all outputs 0 immediately.
//    After release with no req, stays IDLE, busy=0.
//  2 Single: req=0001, in[7:0]=8'hA5, odd_sel=0 -> gnt=0001 for 1 cycle.
//    8 cycles later out_valid=1, out=0, out_id=0.
//  3 Odd: client 2, in=8'h07, odd_sel[2]=1 -> out=0, out_id=2.
//    Client 2 with 8'h06, odd_sel[2]=1 -> out=1.
//  4 RR: req=1111 held, out_ready=1 -> out_id sequence 0,1,2,3,0.
//    gnt spacing DW+2=10 cycles.
//  5 Backpressure: out_ready=0 for 20 cycles in HOLD -> out/out_id stable, no new gnt.
//    out_ready=1 -> valid drops next edge, next gnt 1 cycle later.
//  6 ERRCHK_EN: in=8'h01, odd_sel=0, exp_par=0 -> out=1, out_err=1.
//    exp_par=1 -> out_err=0.

Source files
------------

// File: rtl/parity_sched_if.sv
// Client/result bundle for the shared bit-serial parity engine.
// exp_par/out_err are present only when PARITY_SCHED_ERRCHK_EN is defined.
interface parity_sched_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] in;
  logic [NREQ-1:0]    odd_sel;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic               out;
  logic [IDW-1:0]     out_id;
`ifdef PARITY_SCHED_ERRCHK_EN
  logic [NREQ-1:0]    exp_par;
  logic               out_err;

  modport master (output req, in, odd_sel, out_ready, exp_par,
                  input  gnt, busy, out_valid, out, out_id, out_err);
  modport slave  (input  req, in, odd_sel, out_ready, exp_par,
                  output gnt, busy, out_valid, out, out_id, out_err);
`else
  modport master (output req, in, odd_sel, out_ready,
                  input  gnt, busy, out_valid, out, out_id);
  modport slave  (input  req, in, odd_sel, out_ready,
                  output gnt, busy, out_valid, out, out_id);
`endif
endinterface

// File: rtl/parity_sched.sv
// Round-robin shared bit-serial parity engine: grant, capture, shift DW bits, hold result.
// Optional expected-parity compare enabled by defining PARITY_SCHED_ERRCHK_EN.
module parity_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int IDW  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  parity_sched_if.slave bus
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_ptr;
  logic [DW-1:0]   r_sreg;
  logic [CW-1:0]   r_cnt;
  logic            r_acc;
  logic            r_odd;
  logic [NREQ-1:0] r_gnt;
  logic            r_valid;
  logic            r_out;
  logic [IDW-1:0]  r_id;

  logic            w_pick_vld;
  logic [IDW-1:0]  w_pick_idx;
  logic [NREQ-1:0] w_pick_oh;
  logic [IDW-1:0]  w_next_ptr;
  logic [DW-1:0]   w_pick_data;
  logic            w_pick_odd;
  logic            w_final;
`ifdef PARITY_SCHED_ERRCHK_EN
  logic            r_exp;
  logic            r_err;
  logic            w_pick_exp;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_pick_vld  = 1'b0;
    w_pick_idx  = '0;
    w_pick_oh   = '0;
    w_next_ptr  = r_ptr;
    w_pick_data = '0;
    w_pick_odd  = 1'b0;
`ifdef PARITY_SCHED_ERRCHK_EN
    w_pick_exp  = 1'b0;
`endif
    // Scan offsets from the pointer; first requester hit wins.
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_pick_vld && bus.req[i] && ((int'(r_ptr) + k) % NREQ == i)) begin
          w_pick_vld = 1'b1;
          w_pick_idx = IDW'(i);
          w_next_ptr = IDW'((i + 1) % NREQ);
        end
      end
    end
    // Only the granted lane is read, so idle lanes may carry X.
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick_vld && w_pick_idx == IDW'(i)) begin
        w_pick_oh[i] = 1'b1;
        w_pick_data  = bus.in[i*DW +: DW];
        w_pick_odd   = bus.odd_sel[i];
`ifdef PARITY_SCHED_ERRCHK_EN
        w_pick_exp   = bus.exp_par[i];
`endif
      end
    end
  end

  assign w_final = r_acc ^ r_sreg[0] ^ r_odd;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_acc   <= 1'b0;
      r_odd   <= 1'b0;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_out   <= 1'b0;
      r_id    <= '0;
`ifdef PARITY_SCHED_ERRCHK_EN
      r_exp   <= 1'b0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_gnt <= '0;
      case (r_state)
        IDLE: begin
          if (w_pick_vld) begin
            r_gnt   <= w_pick_oh;
            r_sreg  <= w_pick_data;
            r_odd   <= w_pick_odd;
            r_id    <= w_pick_idx;
            r_ptr   <= w_next_ptr;
            r_cnt   <= CW'(DW);
            r_acc   <= 1'b0;
`ifdef PARITY_SCHED_ERRCHK_EN
            r_exp   <= w_pick_exp;
`endif
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_acc  <= r_acc ^ r_sreg[0];
          r_sreg <= r_sreg >> 1;
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_out   <= w_final;
            r_valid <= 1'b1;
`ifdef PARITY_SCHED_ERRCHK_EN
            r_err   <= w_final ^ r_exp;
`endif
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.busy      = (r_state != IDLE);
  assign bus.out_valid = r_valid;
  assign bus.out       = r_out;
  assign bus.out_id    = r_id;
`ifdef PARITY_SCHED_ERRCHK_EN
  assign bus.out_err   = r_err;
`endif

endmodule

// File: tb/tb_parity_sched.sv
// Scoreboard bench for parity_sched: grants are predicted by a round-robin model,
// expected results queued at capture and compared at each output handshake.
module tb_parity_sched;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  parity_sched_if #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) bus ();

  parity_sched #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int   id;
    logic par;
    logic err;
  } exp_t;

  exp_t sb[$];
  int   gnt_log[$];
  int   gnt_cyc[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   mptr    = 0;

  logic [NREQ-1:0]    s_req;
  logic [NREQ-1:0]    s_odd;
  logic [NREQ-1:0]    s_exp;
  logic [NREQ*DW-1:0] s_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Inputs as seen by the DUT at each rising edge.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    s_req <= bus.req;
    s_odd <= bus.odd_sel;
    s_in  <= bus.in;
`ifdef PARITY_SCHED_ERRCHK_EN
    s_exp <= bus.exp_par;
`else
    s_exp <= '0;
`endif
  end

  always @(negedge clk) begin
    int   g;
    exp_t e;
    exp_t got_e;
    if (rst_n) begin
      if (bus.gnt != '0) begin
        g = pick(s_req, mptr);
        check("gnt_onehot", 32'(bus.gnt), (g < 0) ? 32'd0 : (32'd1 << g));
        if (g >= 0) begin
          e.id  = g;
          e.par = (^s_in[g*DW +: DW]) ^ s_odd[g];
          e.err = e.par ^ s_exp[g];
          sb.push_back(e);
          mptr = (g + 1) % NREQ;
          gnt_log.push_back(g);
          gnt_cyc.push_back(cyc);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_nonempty", 32'(sb.size()), 32'd1);
        end else begin
          got_e = sb.pop_front();
          check("out_id", 32'(bus.out_id), 32'(got_e.id));
          check("out_par", 32'(bus.out), 32'(got_e.par));
`ifdef PARITY_SCHED_ERRCHK_EN
          check("out_err", 32'(bus.out_err), 32'(got_e.err));
`endif
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_gnt"},   32'(bus.gnt), 32'd0);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out"},   32'(bus.out), 32'd0);
    check({tag, "_id"},    32'(bus.out_id), 32'd0);
`ifdef PARITY_SCHED_ERRCHK_EN
    check({tag, "_err"},   32'(bus.out_err), 32'd0);
`endif
  endtask

  task automatic wait_gnt(input string tag);
    int n = 0;
    while (bus.gnt == '0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_gnt_seen"}, 32'(bus.gnt != '0), 32'd1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((bus.busy || sb.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, 32'(bus.busy || sb.size() != 0), 32'd0);
  endtask

  task automatic run_op(input string tag, input int c, input logic [DW-1:0] d,
                        input logic odd, input logic ep);
    @(posedge clk); #1;
    bus.in[c*DW +: DW] = d;
    bus.odd_sel[c]     = odd;
`ifdef PARITY_SCHED_ERRCHK_EN
    bus.exp_par[c]     = ep;
`else
    if (ep) bus.odd_sel[c] = odd;
`endif
    bus.req = NREQ'(1) << c;
    wait_gnt(tag);
    bus.req = '0;
    drain(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [DW-1:0] lane;
    logic          lodd;
    bus.req = '0;
    bus.in = '0;
    bus.odd_sel = '0;
    bus.out_ready = 1'b1;
`ifdef PARITY_SCHED_ERRCHK_EN
    bus.exp_par = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst");
    rst_n = 1'b1;

    // Single request, even parity of A5 -> 0, latency DW.
    @(posedge clk); #1;
    bus.in[7:0] = 8'hA5;
    bus.req = 4'b0001;
    wait_gnt("t2");
    check("t2_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    @(negedge clk);
    check("t2_gnt_pulse", 32'(bus.gnt), 32'd0);
    check("t2_busy", 32'(bus.busy), 32'd1);
    n = 1;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t2_latency", 32'(n), 32'd8);
    check("t2_out", 32'(bus.out), 32'd0);
    check("t2_id", 32'(bus.out_id), 32'd0);
    drain("t2");

    // Odd parity on client 2.
    run_op("t3a", 2, 8'h07, 1'b1, 1'b0);
    run_op("t3b", 2, 8'h06, 1'b1, 1'b0);

    // Reset in the middle of SHIFT discards the operation.
    @(posedge clk); #1;
    bus.in[7:0] = 8'hFF;
    bus.odd_sel = 4'b0001;
    bus.req = 4'b0001;
    wait_gnt("t1");
    bus.req = '0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("t1_rst");
    sb.delete();
    mptr = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1_idle_busy", 32'(bus.busy), 32'd0);
      check("t1_idle_gnt", 32'(bus.gnt), 32'd0);
    end

    // All requesters held: grants rotate 0,1,2,3,0 every DW+2 cycles.
    gnt_log.delete();
    gnt_cyc.delete();
    @(posedge clk); #1;
    bus.in = NREQ*DW'($urandom);
    bus.odd_sel = NREQ'($urandom);
    bus.req = 4'b1111;
    n = 0;
    while (gnt_log.size() < 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.req = '0;
    check("t4_count", 32'(gnt_log.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < gnt_log.size(); i++) begin
      check("t4_seq", 32'(gnt_log[i]), 32'(i % NREQ));
      if (i > 0) check("t4_spacing", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'(DW + 2));
    end
    drain("t4");

    // Backpressure: HOLD keeps result stable, no new grant while stalled.
    @(posedge clk); #1;
    lane = DW'($urandom);
    lodd = 1'($urandom);
    bus.in[2*DW +: DW] = lane;
    bus.odd_sel[2] = lodd;
    bus.out_ready = 1'b0;
    bus.req = 4'b0100;
    wait_gnt("t5");
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_valid_seen", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t5_hold_valid", 32'(bus.out_valid), 32'd1);
      check("t5_hold_out", 32'(bus.out), 32'((^lane) ^ lodd));
      check("t5_hold_id", 32'(bus.out_id), 32'd2);
      check("t5_hold_gnt", 32'(bus.gnt), 32'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_valid_drop", 32'(bus.out_valid), 32'd0);
    check("t5_gnt_gap", 32'(bus.gnt), 32'd0);
    @(negedge clk);
    check("t5_regrant", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    drain("t5");

`ifdef PARITY_SCHED_ERRCHK_EN
    run_op("t6a", 1, 8'h01, 1'b0, 1'b0);
    run_op("t6b", 1, 8'h01, 1'b0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
